// File: rtl/keccak_byte_packer.sv
// Byte-stream front end for the keccak core: packs bytes big-endian into
// 32-bit words, drives the core's word/last/byte_num handshake, captures the
// digest and pulses a core reset between messages.
module keccak_byte_packer #(
   parameter int unsigned OUT_W = 512
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [31:0]      core_in,
   output logic             core_in_ready,
   output logic             core_is_last,
   output logic [1:0]       core_byte_num,
   input  logic             core_buffer_full,
   input  logic [OUT_W-1:0] core_out,
   input  logic             core_out_ready,
   output logic             core_reset,
   output logic [OUT_W-1:0] digest,
   output logic             digest_valid,
   output logic             busy
);

   typedef enum logic [2:0] {
      StFill,
      StSend,
      StSendPad,
      StSendLast,
      StWaitOut,
      StCoreRst
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_cnt, w_cnt_nxt;
   // Only the first three bytes of a word need storing; the fourth goes
   // straight from s_data into core_in.
   logic [23:0]        r_acc, w_acc_nxt;
   logic [31:0]        r_core_in, w_core_in_nxt;
   logic               r_in_ready, w_in_ready_nxt;
   logic               r_is_last, w_is_last_nxt;
   logic [1:0]         r_byte_num, w_byte_num_nxt;
   logic [OUT_W-1:0]   r_digest, w_digest_nxt;
   logic               r_digest_valid, w_digest_valid_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_core_rst, w_core_rst_nxt;

   logic [31:0]        w_word;
   logic               w_xfer;

   assign w_xfer        = r_in_ready & ~core_buffer_full;
   assign s_ready       = (r_state == StFill) & ~reset;
   assign core_reset    = reset | r_core_rst;
   assign core_in       = r_core_in;
   assign core_in_ready = r_in_ready;
   assign core_is_last  = r_is_last;
   assign core_byte_num = r_byte_num;
   assign digest        = r_digest;
   assign digest_valid  = r_digest_valid;
   assign busy          = r_busy;

   // Merge the incoming byte into the partial word; unused low bytes are zero.
   always_comb begin
      w_word = 32'h0;
      unique case (r_cnt)
         2'd0: w_word = {s_data, 24'h0};
         2'd1: w_word = {r_acc[23:16], s_data, 16'h0};
         2'd2: w_word = {r_acc[23:8], s_data, 8'h0};
         2'd3: w_word = {r_acc, s_data};
         default: w_word = 32'h0;
      endcase
   end

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_acc_nxt          = r_acc;
      w_core_in_nxt      = r_core_in;
      w_in_ready_nxt     = r_in_ready;
      w_is_last_nxt      = r_is_last;
      w_byte_num_nxt     = r_byte_num;
      w_digest_nxt       = r_digest;
      w_digest_valid_nxt = r_digest_valid;
      w_core_rst_nxt     = 1'b0;

      unique case (r_state)
         StFill: begin
            if (s_valid) begin
               // digest_valid is already low after the first byte, so
               // clearing on every word start is equivalent.
               if (r_cnt == 2'd0) w_digest_valid_nxt = 1'b0;
               if (!s_last && r_cnt != 2'd3) begin
                  w_cnt_nxt = r_cnt + 2'd1;
                  w_acc_nxt = w_word[31:8];
               end else begin
                  w_cnt_nxt      = 2'd0;
                  w_core_in_nxt  = w_word;
                  w_in_ready_nxt = 1'b1;
                  if (!s_last) begin
                     w_is_last_nxt  = 1'b0;
                     w_byte_num_nxt = 2'd0;
                     w_state_nxt    = StSend;
                  end else if (r_cnt == 2'd3) begin
                     w_is_last_nxt  = 1'b0;
                     w_byte_num_nxt = 2'd0;
                     w_state_nxt    = StSendPad;
                  end else begin
                     w_is_last_nxt  = 1'b1;
                     w_byte_num_nxt = r_cnt + 2'd1;
                     w_state_nxt    = StSendLast;
                  end
               end
            end
         end
         StSend: begin
            if (w_xfer) begin
               w_in_ready_nxt = 1'b0;
               w_state_nxt    = StFill;
            end
         end
         StSendPad: begin
            // Full final word accepted; follow with an empty last word.
            if (w_xfer) begin
               w_core_in_nxt  = 32'h0;
               w_is_last_nxt  = 1'b1;
               w_byte_num_nxt = 2'd0;
               w_state_nxt    = StSendLast;
            end
         end
         StSendLast: begin
            if (w_xfer) begin
               w_in_ready_nxt = 1'b0;
               w_is_last_nxt  = 1'b0;
               w_byte_num_nxt = 2'd0;
               w_state_nxt    = StWaitOut;
            end
         end
         StWaitOut: begin
            if (core_out_ready) begin
               w_digest_nxt       = core_out;
               w_digest_valid_nxt = 1'b1;
               w_core_rst_nxt     = 1'b1;
               w_state_nxt        = StCoreRst;
            end
         end
         StCoreRst: begin
            w_state_nxt = StFill;
         end
         default: begin
            w_state_nxt = StFill;
         end
      endcase

      w_busy_nxt = !((w_state_nxt == StFill) && (w_cnt_nxt == 2'd0));
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= StFill;
         r_cnt          <= 2'd0;
         r_acc          <= 24'h0;
         r_core_in      <= 32'h0;
         r_in_ready     <= 1'b0;
         r_is_last      <= 1'b0;
         r_byte_num     <= 2'd0;
         r_digest       <= '0;
         r_digest_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_core_rst     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_acc          <= w_acc_nxt;
         r_core_in      <= w_core_in_nxt;
         r_in_ready     <= w_in_ready_nxt;
         r_is_last      <= w_is_last_nxt;
         r_byte_num     <= w_byte_num_nxt;
         r_digest       <= w_digest_nxt;
         r_digest_valid <= w_digest_valid_nxt;
         r_busy         <= w_busy_nxt;
         r_core_rst     <= w_core_rst_nxt;
      end
   end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer with a word scoreboard.
module tb_keccak_byte_packer;

   localparam int unsigned OUT_W = 512;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       s_data;
   logic             s_valid;
   logic             s_last;
   logic             s_ready;
   logic [31:0]      core_in;
   logic             core_in_ready;
   logic             core_is_last;
   logic [1:0]       core_byte_num;
   logic             core_buffer_full;
   logic [OUT_W-1:0] core_out;
   logic             core_out_ready;
   logic             core_reset;
   logic [OUT_W-1:0] digest;
   logic             digest_valid;
   logic             busy;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic [1:0]  bn;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   xfers    = 0;
   int   n_last   = 0;

   keccak_byte_packer #(.OUT_W(OUT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .s_data           (s_data),
      .s_valid          (s_valid),
      .s_last           (s_last),
      .s_ready          (s_ready),
      .core_in          (core_in),
      .core_in_ready    (core_in_ready),
      .core_is_last     (core_is_last),
      .core_byte_num    (core_byte_num),
      .core_buffer_full (core_buffer_full),
      .core_out         (core_out),
      .core_out_ready   (core_out_ready),
      .core_reset       (core_reset),
      .digest           (digest),
      .digest_valid     (digest_valid),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_w(input logic [31:0] d, input logic l, input logic [1:0] bn);
      exp_t e;
      e.d  = d;
      e.l  = l;
      e.bn = bn;
      sb.push_back(e);
   endtask

   // Reference packing: big-endian words, short tail carries its byte count,
   // an exact multiple of four ends with an empty last word.
   task automatic push_exp(input string m);
      for (int i = 0; i < m.len(); i += 4) begin
         logic [31:0] w;
         int          rem;
         w   = 32'h0;
         rem = m.len() - i;
         for (int j = 0; j < 4; j++)
            if (i + j < m.len()) w[31-8*j -: 8] = m[i+j];
         if (rem > 4) begin
            push_w(w, 1'b0, 2'd0);
         end else if (rem == 4) begin
            push_w(w, 1'b0, 2'd0);
            push_w(32'h0, 1'b1, 2'd0);
         end else begin
            push_w(w, 1'b1, 2'(rem));
         end
      end
   endtask

   // Present one byte at a negedge and return at the negedge after acceptance.
   task automatic drive_byte(input logic [7:0] b, input logic last);
      int n;
      s_data  = b;
      s_valid = 1'b1;
      s_last  = last;
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("byte_accept", 32'(s_ready), 1);
      @(negedge clk);
   endtask

   task automatic drive_str(input string m, input int from, input int to);
      for (int i = from; i < to; i++) drive_byte(m[i], i == m.len() - 1);
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Wait for all expected words, answer with a digest, check capture and reset pulse.
   task automatic finish_msg(input logic [OUT_W-1:0] pat);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", sb.size(), 0);
      @(negedge clk);
      core_out       = pat;
      core_out_ready = 1'b1;
      @(negedge clk);
      core_out_ready = 1'b0;
      core_out       = ~pat;
      chk("core_reset_pulse", 32'(core_reset), 1);
      chkd("digest", digest, pat);
      chk("digest_valid", 32'(digest_valid), 1);
      chk("s_ready_corerst", 32'(s_ready), 0);
      chk("busy_corerst", 32'(busy), 1);
      @(negedge clk);
      chk("core_reset_end", 32'(core_reset), 0);
      chk("s_ready_idle", 32'(s_ready), 1);
      chk("busy_idle", 32'(busy), 0);
   endtask

   // Scoreboard monitor, sampled mid-low-phase after stimulus has settled.
   always begin
      @(negedge clk);
      #2;
      if (reset === 1'b0 && core_in_ready === 1'b1 && core_buffer_full === 1'b0) begin
         xfers++;
         if (sb.size() == 0) begin
            chk("sb_unexpected_word", core_in, 32'hxxxxxxxx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("word_data", core_in, e.d);
            chk("word_last", 32'(core_is_last), 32'(e.l));
            if (e.l) chk("word_bnum", 32'(core_byte_num), 32'(e.bn));
         end
         if (core_is_last === 1'b1) n_last++;
      end
   end

   initial begin
      logic [OUT_W-1:0] p1, p2, p3, p4, p5, p6, p7;
      string m1, m2;
      int    l0, x0, k;
      p1 = {16{32'hC0DE0001}};
      p2 = {16{32'h1234ABCD}};
      p3 = {8{64'hFEEDFACE_00000003}};
      p4 = {16{32'h5A5A0004}};
      p5 = {16{32'h0BADBEEF}};
      p6 = {16{32'h66660006}};
      p7 = {16{32'h77770007}};

      reset = 1'b1;
      s_data = 8'h0;
      s_valid = 1'b0;
      s_last = 1'b0;
      core_buffer_full = 1'b0;
      core_out = '0;
      core_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_core_in", core_in, 0);
      chk("rst_in_ready", 32'(core_in_ready), 0);
      chk("rst_is_last", 32'(core_is_last), 0);
      chk("rst_byte_num", 32'(core_byte_num), 0);
      chkd("rst_digest", digest, '0);
      chk("rst_digest_valid", 32'(digest_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 1);
      chk("post_rst_core_reset", 32'(core_reset), 0);

      // core_out_ready outside WAIT_OUT has no effect
      core_out = p5;
      core_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      core_out_ready = 1'b0;
      chkd("ignored_digest", digest, '0);
      chk("ignored_dvalid", 32'(digest_valid), 0);
      chk("ignored_core_reset", 32'(core_reset), 0);

      // 13 bytes, single-byte tail
      m1 = "Hello, world!";
      push_exp(m1);
      drive_str(m1, 0, 2);
      chk("busy_mid_msg", 32'(busy), 1);
      drive_str(m1, 2, m1.len());
      idle();
      chk("lat_in_ready", 32'(core_in_ready), 1);
      chk("lat_is_last", 32'(core_is_last), 1);
      chk("lat_core_in", core_in, 32'h21000000);
      chk("lat_byte_num", 32'(core_byte_num), 1);
      finish_msg(p1);

      // 12 bytes, empty final word
      push_exp("Hello, world");
      drive_str("Hello, world", 0, 12);
      idle();
      finish_msg(p2);

      // 43 bytes, three-byte tail
      m1 = "The quick brown fox jumps over the lazy dog";
      push_exp(m1);
      drive_str(m1, 0, m1.len());
      idle();
      chk("dog_core_in", core_in, 32'h646F6700);
      chk("dog_byte_num", 32'(core_byte_num), 3);
      finish_msg(p3);

      // back-pressure on a full word
      m1 = "ABCDEFG";
      push_exp(m1);
      core_buffer_full = 1'b1;
      x0 = xfers;
      drive_str(m1, 0, 4);
      idle();
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", 32'(core_in_ready), 1);
         chk("stall_core_in", core_in, 32'h41424344);
         chk("stall_is_last", 32'(core_is_last), 0);
         chk("stall_s_ready", 32'(s_ready), 0);
         @(negedge clk);
      end
      chk("stall_no_xfer", xfers, x0);
      core_buffer_full = 1'b0;
      @(negedge clk);
      chk("stall_one_xfer", xfers, x0 + 1);
      chk("stall_in_ready_drop", 32'(core_in_ready), 0);
      drive_str(m1, 4, m1.len());
      idle();
      finish_msg(p4);

      // reset mid-message discards the partial word
      push_w(32'h61626364, 1'b0, 2'd0);
      drive_str("abcdefghij", 0, 6);
      idle();
      reset = 1'b1;
      #1;
      chk("midrst_s_ready", 32'(s_ready), 0);
      chk("midrst_core_reset", 32'(core_reset), 1);
      @(negedge clk);
      chk("midrst_core_in", core_in, 0);
      chk("midrst_in_ready", 32'(core_in_ready), 0);
      chk("midrst_is_last", 32'(core_is_last), 0);
      chkd("midrst_digest", digest, '0);
      chk("midrst_dvalid", 32'(digest_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      reset = 1'b0;
      #1;
      chk("midrst_sb_empty", sb.size(), 0);
      chk("midrst_s_ready_after", 32'(s_ready), 1);
      push_exp("1234567890");
      drive_str("1234567890", 0, 10);
      idle();
      chk("num_core_in", core_in, 32'h39300000);
      chk("num_byte_num", 32'(core_byte_num), 2);
      finish_msg(p5);

      // back-to-back messages with s_valid held high
      m1 = "ab";
      m2 = "xyz12";
      push_exp(m1);
      push_exp(m2);
      l0 = n_last;
      drive_str(m1, 0, m1.len());
      chk("b2b_s_ready_low", 32'(s_ready), 0);
      fork
         begin
            s_data  = m2[0];
            s_valid = 1'b1;
            s_last  = 1'b0;
            k = 0;
            while (s_ready !== 1'b1 && k < 100) begin
               @(negedge clk);
               k++;
            end
            chk("b2b_ready_after_capture", 32'(digest_valid), 1);
            chk("b2b_ready_not_in_corerst", 32'(core_reset), 0);
            @(negedge clk);
            chk("b2b_dvalid_cleared", 32'(digest_valid), 0);
            chkd("b2b_digest1", digest, p6);
            drive_str(m2, 1, m2.len());
            idle();
         end
         begin
            int n;
            n = 0;
            while (n_last == l0 && n < 200) begin
               @(negedge clk);
               n++;
            end
            core_out       = p6;
            core_out_ready = 1'b1;
            @(negedge clk);
            core_out_ready = 1'b0;
            core_out       = '0;
         end
      join
      finish_msg(p7);

      chk("final_sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
